// File: rtl/rs_syndrome_calc.sv
// First stage of the GF(2^5) Reed-Solomon decoder: accumulates S_1..S_NSYN of one
// received codeword with Horner's rule and hands them downstream with an error flag.
module rs_syndrome_calc #(
    parameter int N    = 31,
    parameter int NSYN = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4:0]            sym_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [5*NSYN-1:0]     syn_out,
    output logic                  err_det,
    output logic                  out_valid,
    input  logic                  out_ready
);

    // Handshake: a transfer happens on an edge where valid and ready are both 1;
    // in_ready/out_valid come straight from the state register.
    localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    // alpha^1 .. alpha^8 for p(x) = x^5 + x^2 + 1, alpha^1 in the low slice.
    localparam logic [39:0] ALPHA_POW = {5'b01101, 5'b10100, 5'b01010, 5'b00101,
                                         5'b10000, 5'b01000, 5'b00100, 5'b00010};

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [4:0]       syn_q    [NSYN];
    logic [4:0]       syn_next [NSYN];
    logic             accept;
    logic             last_accept;
    logic             any_nonzero;

    function automatic logic [4:0] gf_add(input logic [4:0] a, input logic [4:0] b);
        return a ^ b;
    endfunction

    // Multiply by alpha (x), reducing x^5 -> x^2 + 1.
    function automatic logic [4:0] gf_xtime(input logic [4:0] v);
        return {v[3:0], 1'b0} ^ (v[4] ? 5'b00101 : 5'b00000);
    endfunction

    function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] acc;
        logic [4:0] sh;
        acc = '0;
        sh  = a;
        for (int k = 0; k < 5; k++) begin
            if (b[k]) acc = gf_add(acc, sh);
            sh = gf_xtime(sh);
        end
        return acc;
    endfunction

    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == HOLD);

    always_comb begin
        accept      = in_valid && (state == COLLECT);
        last_accept = accept && (count == LAST_IDX);
        any_nonzero = 1'b0;
        for (int i = 0; i < NSYN; i++) begin
            // The first symbol of a frame overwrites whatever the previous frame left.
            if (count == '0) begin
                syn_next[i] = sym_in;
            end else begin
                syn_next[i] = gf_add(gf_mul(syn_q[i], ALPHA_POW[5*i +: 5]), sym_in);
            end
            any_nonzero = any_nonzero | (|syn_next[i]);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (last_accept) state_next = HOLD;
            HOLD:    if (out_ready)   state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= COLLECT;
            count   <= '0;
            err_det <= 1'b0;
            for (int i = 0; i < NSYN; i++) syn_q[i] <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                count <= last_accept ? '0 : count + CNT_W'(1);
                for (int i = 0; i < NSYN; i++) syn_q[i] <= syn_next[i];
            end
            if (last_accept) err_det <= any_nonzero;
        end
    end

    always_comb begin
        syn_out = '0;
        for (int i = 0; i < NSYN; i++) syn_out[5*i +: 5] = syn_q[i];
    end

endmodule
